// File: rtl/snn_ff_pkg.sv
// Shared definitions for the spiking-neuron scheduling blocks: sweep FSM
// state encoding and the helper used to derive index widths.
package snn_ff_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_EV_RD   = 4'd1,
        ST_EV_LAT  = 4'd2,
        ST_EV_WR   = 4'd3,
        ST_EV_ACK  = 4'd4,
        ST_TS_RD   = 4'd5,
        ST_TS_WR   = 4'd6,
        ST_TS_SPK  = 4'd7,
        ST_TREF_WR = 4'd8
    } sched_state_e;

    // Width of an index able to address n entries; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/neur_event_sched.sv
// Neuron event scheduler: sweeps every post-synaptic neuron for each incoming
// AER event, each end-of-time-step pulse and each reference-reset pulse,
// driving the state/weight SRAM controls and the neuron update strobes.
module neur_event_sched
    import snn_ff_pkg::*;
#(
    parameter int POST_NEUR_NUM             = 256,
    parameter int TIME_STEP                 = 8,
    parameter int AER_IN_CORE_WIDTH         = 12,
    parameter int POST_NEUR_MEM_WIDTH       = 12,
    parameter int POST_NEUR_SPIKE_CNT_WIDTH = 7,
    parameter int WEIGHT_WIDTH              = 8,
    localparam int IDX_W = idx_width(POST_NEUR_NUM),
    localparam int TS_W  = idx_width(TIME_STEP)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [AER_IN_CORE_WIDTH-1:0]       AERIN_ADDR,
    input  logic                               AERIN_REQ,
    output logic                               AERIN_ACK,
    input  logic                               CTRL_TSTEP,
    input  logic                               CTRL_TREF,
    output logic                               CTRL_BUSY,
    output logic                               CTRL_DONE,
    output logic [IDX_W-1:0]                   NEUR_ADDR,
    output logic                               NEUR_CS,
    output logic                               NEUR_WE,
    output logic [AER_IN_CORE_WIDTH+IDX_W-1:0] SYN_ADDR,
    output logic                               SYN_CS,
    output logic                               neuron_event,
    output logic                               time_step_event,
    output logic                               time_ref_event,
    output logic [TS_W-1:0]                    current_time_step,
    input  logic                               spike_out,
    output logic [IDX_W-1:0]                   AEROUT_ADDR,
    output logic                               AEROUT_REQ,
    input  logic                               AEROUT_ACK
);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(POST_NEUR_NUM - 1);
    localparam logic [TS_W-1:0]  TS_ZERO  = {TS_W{1'b0}};
    localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
    localparam logic [TS_W-1:0]  TS_LAST  = TS_W'(TIME_STEP - 1);

    // The neuron datapath widths only describe the attached SRAM words; reject
    // a configuration where any of them is meaningless.
    if (POST_NEUR_MEM_WIDTH < 1 || POST_NEUR_SPIKE_CNT_WIDTH < 1 ||
        WEIGHT_WIDTH < 1 || AER_IN_CORE_WIDTH < 1) begin : g_bad_cfg
        $error("neur_event_sched: datapath widths must be positive");
    end

    sched_state_e                 state_r;
    logic [IDX_W-1:0]             idx_r;
    logic [AER_IN_CORE_WIDTH-1:0] aer_addr_r;
    logic                         pend_tref_r;
    logic                         pend_tstep_r;

    logic                         start_tref_s;
    logic                         start_tstep_s;
    logic                         last_s;
    logic [IDX_W-1:0]             idx_nxt_s;
    logic [TS_W-1:0]              ts_nxt_s;

    // Sweep start selection from IDLE: reference reset beats time step.
    assign start_tref_s  = (state_r == ST_IDLE) && pend_tref_r;
    assign start_tstep_s = (state_r == ST_IDLE) && !pend_tref_r && pend_tstep_r;
    assign last_s        = (idx_r == IDX_LAST);
    assign idx_nxt_s     = idx_r + IDX_ONE;
    assign ts_nxt_s      = (current_time_step == TS_LAST) ? TS_ZERO
                                                          : current_time_step + TS_ONE;

    // Pending control pulses: a new pulse wins over the clear at sweep start.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_tref_r  <= 1'b0;
            pend_tstep_r <= 1'b0;
        end else begin
            pend_tref_r  <= CTRL_TREF  | (pend_tref_r  & ~start_tref_s);
            pend_tstep_r <= CTRL_TSTEP | (pend_tstep_r & ~start_tstep_s);
        end
    end

    // Sweep FSM; every output is registered and set for the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r           <= ST_IDLE;
            idx_r             <= IDX_ZERO;
            aer_addr_r        <= {AER_IN_CORE_WIDTH{1'b0}};
            current_time_step <= TS_ZERO;
            AERIN_ACK         <= 1'b0;
            CTRL_BUSY         <= 1'b0;
            CTRL_DONE         <= 1'b0;
            NEUR_ADDR         <= IDX_ZERO;
            NEUR_CS           <= 1'b0;
            NEUR_WE           <= 1'b0;
            SYN_ADDR          <= {(AER_IN_CORE_WIDTH+IDX_W){1'b0}};
            SYN_CS            <= 1'b0;
            neuron_event      <= 1'b0;
            time_step_event   <= 1'b0;
            time_ref_event    <= 1'b0;
            AEROUT_ADDR       <= IDX_ZERO;
            AEROUT_REQ        <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to 0 unless the entered state raises them.
            CTRL_DONE       <= 1'b0;
            NEUR_CS         <= 1'b0;
            NEUR_WE         <= 1'b0;
            SYN_CS          <= 1'b0;
            neuron_event    <= 1'b0;
            time_step_event <= 1'b0;
            time_ref_event  <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    idx_r     <= IDX_ZERO;
                    NEUR_ADDR <= IDX_ZERO;
                    if (pend_tref_r) begin
                        state_r        <= ST_TREF_WR;
                        CTRL_BUSY      <= 1'b1;
                        NEUR_CS        <= 1'b1;
                        NEUR_WE        <= 1'b1;
                        time_ref_event <= 1'b1;
                    end else if (pend_tstep_r) begin
                        state_r   <= ST_TS_RD;
                        CTRL_BUSY <= 1'b1;
                        NEUR_CS   <= 1'b1;
                    end else if (AERIN_REQ && !AERIN_ACK) begin
                        state_r    <= ST_EV_RD;
                        CTRL_BUSY  <= 1'b1;
                        aer_addr_r <= AERIN_ADDR;
                        SYN_ADDR   <= {AERIN_ADDR, IDX_ZERO};
                        NEUR_CS    <= 1'b1;
                        SYN_CS     <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        CTRL_BUSY <= 1'b0;
                    end
                end

                // Addresses stay put while the SRAM read data settles.
                ST_EV_RD: begin
                    state_r <= ST_EV_LAT;
                end

                ST_EV_LAT: begin
                    state_r      <= ST_EV_WR;
                    NEUR_CS      <= 1'b1;
                    NEUR_WE      <= 1'b1;
                    neuron_event <= 1'b1;
                end

                ST_EV_WR: begin
                    if (last_s) begin
                        state_r   <= ST_EV_ACK;
                        idx_r     <= IDX_ZERO;
                        NEUR_ADDR <= IDX_ZERO;
                        AERIN_ACK <= 1'b1;
                    end else begin
                        state_r   <= ST_EV_RD;
                        idx_r     <= idx_nxt_s;
                        NEUR_ADDR <= idx_nxt_s;
                        SYN_ADDR  <= {aer_addr_r, idx_nxt_s};
                        NEUR_CS   <= 1'b1;
                        SYN_CS    <= 1'b1;
                    end
                end

                // Four-phase input handshake: release ACK once the sender drops REQ.
                ST_EV_ACK: begin
                    if (!AERIN_REQ) begin
                        state_r   <= ST_IDLE;
                        AERIN_ACK <= 1'b0;
                        CTRL_BUSY <= 1'b0;
                        CTRL_DONE <= 1'b1;
                    end else begin
                        state_r <= ST_EV_ACK;
                    end
                end

                ST_TS_RD: begin
                    state_r         <= ST_TS_WR;
                    NEUR_CS         <= 1'b1;
                    NEUR_WE         <= 1'b1;
                    time_step_event <= 1'b1;
                end

                ST_TS_WR: begin
                    if (spike_out) begin
                        state_r     <= ST_TS_SPK;
                        AEROUT_ADDR <= idx_r;
                        AEROUT_REQ  <= 1'b1;
                    end else if (last_s) begin
                        state_r           <= ST_IDLE;
                        idx_r             <= IDX_ZERO;
                        NEUR_ADDR         <= IDX_ZERO;
                        current_time_step <= ts_nxt_s;
                        CTRL_BUSY         <= 1'b0;
                        CTRL_DONE         <= 1'b1;
                    end else begin
                        state_r   <= ST_TS_RD;
                        idx_r     <= idx_nxt_s;
                        NEUR_ADDR <= idx_nxt_s;
                        NEUR_CS   <= 1'b1;
                    end
                end

                // Four-phase output handshake, then resume the sweep at the next neuron.
                ST_TS_SPK: begin
                    if (AEROUT_REQ) begin
                        AEROUT_REQ <= !AEROUT_ACK;
                    end else if (!AEROUT_ACK) begin
                        AEROUT_ADDR <= IDX_ZERO;
                        if (last_s) begin
                            state_r           <= ST_IDLE;
                            idx_r             <= IDX_ZERO;
                            NEUR_ADDR         <= IDX_ZERO;
                            current_time_step <= ts_nxt_s;
                            CTRL_BUSY         <= 1'b0;
                            CTRL_DONE         <= 1'b1;
                        end else begin
                            state_r   <= ST_TS_RD;
                            idx_r     <= idx_nxt_s;
                            NEUR_ADDR <= idx_nxt_s;
                            NEUR_CS   <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_TS_SPK;
                    end
                end

                ST_TREF_WR: begin
                    if (last_s) begin
                        state_r           <= ST_IDLE;
                        idx_r             <= IDX_ZERO;
                        NEUR_ADDR         <= IDX_ZERO;
                        current_time_step <= TS_ZERO;
                        CTRL_BUSY         <= 1'b0;
                        CTRL_DONE         <= 1'b1;
                    end else begin
                        idx_r          <= idx_nxt_s;
                        NEUR_ADDR      <= idx_nxt_s;
                        NEUR_CS        <= 1'b1;
                        NEUR_WE        <= 1'b1;
                        time_ref_event <= 1'b1;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    idx_r      <= IDX_ZERO;
                    NEUR_ADDR  <= IDX_ZERO;
                    AERIN_ACK  <= 1'b0;
                    AEROUT_REQ <= 1'b0;
                    CTRL_BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neur_event_sched.sv
// Scoreboard bench for neur_event_sched with four neurons: stimulus pushes the
// expected event stream, a negedge monitor pops and compares every observed
// strobe, handshake edge and done pulse.
module tb_neur_event_sched;

    localparam int NN = 4;
    localparam int TS = 8;
    localparam int AW = 12;
    localparam int NW = 2;
    localparam int TW = 3;

    localparam int K_NEV  = 1;
    localparam int K_TSE  = 2;
    localparam int K_TRE  = 3;
    localparam int K_SPK  = 4;
    localparam int K_ACK  = 5;
    localparam int K_DONE = 6;

    typedef struct {
        int kind;
        int a;
        int b;
    } exp_t;

    exp_t exp_q[$];

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] AERIN_ADDR = '0;
    logic          AERIN_REQ = 1'b0;
    logic          AERIN_ACK;
    logic          CTRL_TSTEP = 1'b0;
    logic          CTRL_TREF = 1'b0;
    logic          CTRL_BUSY;
    logic          CTRL_DONE;
    logic [NW-1:0] NEUR_ADDR;
    logic          NEUR_CS;
    logic          NEUR_WE;
    logic [AW+NW-1:0] SYN_ADDR;
    logic          SYN_CS;
    logic          neuron_event;
    logic          time_step_event;
    logic          time_ref_event;
    logic [TW-1:0] current_time_step;
    logic          spike_out;
    logic [NW-1:0] AEROUT_ADDR;
    logic          AEROUT_REQ;
    logic          AEROUT_ACK = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_ts    = 0;
    bit rst_seq   = 1'b1;
    bit rsp_en    = 1'b1;
    logic [NN-1:0] spike_mask = '0;

    always #5 CLK = ~CLK;

    // Neuron model: fires only for the masked indices during a time-step write.
    assign spike_out = time_step_event & spike_mask[NEUR_ADDR];

    neur_event_sched #(
        .POST_NEUR_NUM(NN), .TIME_STEP(TS), .AER_IN_CORE_WIDTH(AW),
        .POST_NEUR_MEM_WIDTH(12), .POST_NEUR_SPIKE_CNT_WIDTH(7), .WEIGHT_WIDTH(8)
    ) dut (
        .CLK(CLK), .RST(RST),
        .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
        .CTRL_TSTEP(CTRL_TSTEP), .CTRL_TREF(CTRL_TREF),
        .CTRL_BUSY(CTRL_BUSY), .CTRL_DONE(CTRL_DONE),
        .NEUR_ADDR(NEUR_ADDR), .NEUR_CS(NEUR_CS), .NEUR_WE(NEUR_WE),
        .SYN_ADDR(SYN_ADDR), .SYN_CS(SYN_CS),
        .neuron_event(neuron_event), .time_step_event(time_step_event),
        .time_ref_event(time_ref_event), .current_time_step(current_time_step),
        .spike_out(spike_out),
        .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK)
    );

    task automatic check(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int a, input int b);
        exp_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic push_aer(input int addr);
        for (int i = 0; i < NN; i++) push(K_NEV, i, (addr << NW) | i);
        push(K_ACK, 0, 12);
    endtask

    task automatic pulse_tstep();
        CTRL_TSTEP = 1'b1;
        @(negedge CLK);
        CTRL_TSTEP = 1'b0;
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!AERIN_ACK && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (!AERIN_ACK) begin
            total_cnt++;
            $display("FAIL aerin_ack_timeout: got no ACK after %0d cycles, expected ACK", budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || CTRL_BUSY) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0 || CTRL_BUSY) begin
            total_cnt++;
            $display("FAIL drain_timeout: got %0d pending events busy=%0d, expected 0 and idle",
                     exp_q.size(), CTRL_BUSY);
        end
    endtask

    // Monitor: per-cycle invariants and scoreboard pops.
    int   cyc = 0;
    int   busy_rise = 0;
    logic prev_busy = 1'b0;
    logic prev_ack  = 1'b0;
    logic prev_oreq = 1'b0;

    always @(negedge CLK) begin : mon
        int   kind;
        int   a;
        int   b;
        exp_t e;
        cyc++;
        if (!rst_seq) begin
            check("strobe_onehot",
                  int'($countones({neuron_event, time_step_event, time_ref_event}) <= 1), 1);
            check("we_implies_cs", int'(!NEUR_WE || NEUR_CS), 1);
            if (!CTRL_BUSY) begin
                check("idle_strobes_zero",
                      int'({neuron_event, time_step_event, time_ref_event}), 0);
            end
            if (CTRL_BUSY && !prev_busy) busy_rise = cyc;
            kind = 0; a = 0; b = 0;
            if (neuron_event) begin
                kind = K_NEV; a = int'(NEUR_ADDR); b = int'(SYN_ADDR);
            end else if (time_step_event) begin
                kind = K_TSE; a = int'(NEUR_ADDR); b = int'(current_time_step);
            end else if (time_ref_event) begin
                kind = K_TRE; a = int'(NEUR_ADDR); b = int'(current_time_step);
            end else if (AEROUT_REQ && !prev_oreq) begin
                kind = K_SPK; a = int'(AEROUT_ADDR); b = 0;
            end else if (AERIN_ACK && !prev_ack) begin
                kind = K_ACK; a = 0; b = cyc - busy_rise;
            end else if (CTRL_DONE) begin
                kind = K_DONE; a = int'(current_time_step); b = 0;
            end
            if (kind != 0) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_event: got kind %0d a=%0d b=%0d, expected none",
                             kind, a, b);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, e.kind);
                    check("event_addr", a, e.a);
                    check("event_aux", b, e.b);
                end
            end
        end
        prev_busy = CTRL_BUSY;
        prev_ack  = AERIN_ACK;
        prev_oreq = AEROUT_REQ;
    end

    // AER output receiver: ACK a few cycles late, checking REQ holds until then.
    initial begin
        forever begin
            @(negedge CLK);
            if (rsp_en && AEROUT_REQ) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLK);
                    check("aerout_req_hold", int'(AEROUT_REQ), 1);
                end
                AEROUT_ACK = 1'b1;
                @(negedge CLK);
                check("aerout_req_drop", int'(AEROUT_REQ), 0);
                AEROUT_ACK = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_seen;
        int n;

        // Reset state: everything low while RST is held.
        repeat (3) @(negedge CLK);
        check("rst_busy", int'(CTRL_BUSY), 0);
        check("rst_done", int'(CTRL_DONE), 0);
        check("rst_aerin_ack", int'(AERIN_ACK), 0);
        check("rst_aerout_req", int'(AEROUT_REQ), 0);
        check("rst_sram_ctrl", int'({NEUR_CS, NEUR_WE, SYN_CS}), 0);
        check("rst_strobes", int'({neuron_event, time_step_event, time_ref_event}), 0);
        check("rst_ts", int'(current_time_step), 0);
        check("rst_addrs", int'({NEUR_ADDR, SYN_ADDR, AEROUT_ADDR}), 0);
        RST = 1'b0;
        @(negedge CLK);
        rst_seq = 1'b0;
        @(negedge CLK);

        // One AER event at 0x005: SYN_ADDR 0x14..0x17, ACK 12 cycles in.
        push_aer(12'h005);
        push(K_DONE, exp_ts, 0);
        AERIN_ADDR = 12'h005;
        AERIN_REQ  = 1'b1;
        wait_ack(40);
        AERIN_REQ = 1'b0;
        @(negedge CLK);
        check("aerin_ack_fall", int'(AERIN_ACK), 0);
        wait_drain(50);

        // Time step with neuron 2 spiking; sweep resumes at neuron 3.
        spike_mask = 4'b0100;
        for (int i = 0; i < 3; i++) push(K_TSE, i, exp_ts);
        push(K_SPK, 2, 0);
        push(K_TSE, 3, exp_ts);
        exp_ts = (exp_ts + 1) % TS;
        push(K_DONE, exp_ts, 0);
        pulse_tstep();
        wait_drain(80);
        check("ts_after_spike_sweep", int'(current_time_step), 1);
        spike_mask = '0;

        // TREF (with AERIN_REQ high) and TSTEP during an AER sweep: AER, TREF, TSTEP.
        push_aer(12'h0A3);
        push(K_DONE, exp_ts, 0);
        for (int i = 0; i < NN; i++) push(K_TRE, i, exp_ts);
        exp_ts = 0;
        push(K_DONE, exp_ts, 0);
        for (int i = 0; i < NN; i++) push(K_TSE, i, exp_ts);
        exp_ts = (exp_ts + 1) % TS;
        push(K_DONE, exp_ts, 0);
        AERIN_ADDR = 12'h0A3;
        AERIN_REQ  = 1'b1;
        repeat (3) @(negedge CLK);
        CTRL_TREF = 1'b1;
        @(negedge CLK);
        CTRL_TREF  = 1'b0;
        CTRL_TSTEP = 1'b1;
        @(negedge CLK);
        CTRL_TSTEP = 1'b0;
        wait_ack(40);
        AERIN_REQ = 1'b0;
        @(negedge CLK);
        check("aerin_ack_fall_2", int'(AERIN_ACK), 0);
        wait_drain(120);
        check("ts_after_tref_tstep", int'(current_time_step), exp_ts);

        // Eight sweeps: the step index walks through 7 -> 0.
        for (int s = 0; s < TS; s++) begin
            for (int i = 0; i < NN; i++) push(K_TSE, i, exp_ts);
            exp_ts = (exp_ts + 1) % TS;
            push(K_DONE, exp_ts, 0);
            pulse_tstep();
            wait_drain(40);
            check("ts_sweep_value", int'(current_time_step), exp_ts);
        end

        // Reset while waiting in the spike handshake, with a TSTEP pending.
        rsp_en     = 1'b0;
        spike_mask = 4'b0010;
        push(K_TSE, 0, exp_ts);
        push(K_TSE, 1, exp_ts);
        push(K_SPK, 1, 0);
        pulse_tstep();
        n = 0;
        while (!AEROUT_REQ && n < 20) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        check("aerout_req_waiting", int'(AEROUT_REQ), 1);
        check("sb_empty_before_rst", exp_q.size(), 0);
        CTRL_TSTEP = 1'b1;
        @(negedge CLK);
        CTRL_TSTEP = 1'b0;
        rst_seq    = 1'b1;
        RST        = 1'b1;
        @(negedge CLK);
        check("midrst_busy", int'(CTRL_BUSY), 0);
        check("midrst_aerout_req", int'(AEROUT_REQ), 0);
        check("midrst_neur_we", int'(NEUR_WE), 0);
        check("midrst_ts", int'(current_time_step), 0);
        RST        = 1'b0;
        spike_mask = '0;
        exp_ts     = 0;
        busy_seen  = 0;
        repeat (10) begin
            @(negedge CLK);
            busy_seen = busy_seen | int'(CTRL_BUSY);
        end
        check("no_pending_after_rst", busy_seen, 0);
        rst_seq = 1'b0;
        repeat (2) @(negedge CLK);
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/neur_event_sched.md
NEUR_EVENT_SCHED -- requirements
Module: neur_event_sched

Interface
REQ-001 SHALL have parameters: POST_NEUR_NUM, default 256, number of post-synaptic neurons swept per event.
REQ-002 SHALL have parameters: TIME_STEP 8, AER_IN_CORE_WIDTH 12, POST_NEUR_MEM_WIDTH 12, POST_NEUR_SPIKE_CNT_WIDTH 7, WEIGHT_WIDTH 8, matching the neuron datapath.
REQ-003 SHALL provide ports, one clock and one reset; reset is synchronous and active-high:
 CLK  in  1  clock
 RST  in  1  synchronous active-high reset
 AERIN_ADDR  in  AER_IN_CORE_WIDTH  pre-synaptic event address
 AERIN_REQ / AERIN_ACK  in / out  1  4-phase input handshake
 CTRL_TSTEP  in  1  one-cycle pulse: end of time step
 CTRL_TREF  in  1  one-cycle pulse: reference reset
 CTRL_BUSY / CTRL_DONE  out  1  sweep active / one-cycle sweep-complete pulse
 NEUR_ADDR  out  clog2(POST_NEUR_NUM)  state/count SRAM address
 NEUR_CS / NEUR_WE  out  1  state SRAM select / write enable
 SYN_ADDR  out  AER_IN_CORE_WIDTH+clog2(POST_NEUR_NUM)  weight SRAM address {pre, post}
 SYN_CS  out  1  weight SRAM select
 neuron_event / time_step_event / time_ref_event  out  1  neuron strobes
 current_time_step  out  clog2(TIME_STEP)  time-step index to neuron
 spike_out  in  1  neuron fire flag
 AEROUT_ADDR  out  clog2(POST_NEUR_NUM)  spiking neuron index
 AEROUT_REQ / AEROUT_ACK  out / in  1  4-phase output handshake

Function
REQ-004 SHALL implement FSM states IDLE, EV_RD, EV_LAT, EV_WR, EV_ACK, TS_RD, TS_WR, TS_SPK, TREF_WR.
REQ-005 SHALL latch CTRL_TSTEP and CTRL_TREF into pending flags; a pulse arriving during a sweep is not lost.
REQ-006 SHALL, from IDLE, select by priority: pending TREF > pending TSTEP > AERIN_REQ high with AERIN_ACK low.
REQ-007 SHALL, per neuron in an input-event sweep: EV_RD assert NEUR_CS, SYN_CS and the addresses; EV_LAT hold the addresses while SRAM data is valid (1-cycle read latency; the neuron registers state and weight); EV_WR assert neuron_event and NEUR_WE with the same NEUR_ADDR. 3 cycles per neuron.
REQ-008 SHALL, after the last neuron, enter EV_ACK, raise AERIN_ACK, and hold it until AERIN_REQ is low. It then drops AERIN_ACK, pulses CTRL_DONE and returns to IDLE.
REQ-009 SHALL, per neuron in a TSTEP sweep: TS_RD read; TS_WR assert time_step_event and NEUR_WE, and sample spike_out. If spike_out=1, go to TS_SPK; otherwise go to the next neuron.
REQ-010 SHALL, in TS_SPK, drive AEROUT_ADDR with the neuron index and assert AEROUT_REQ until AEROUT_ACK=1. It deasserts the request, waits for AEROUT_ACK=0, then resumes the sweep.
REQ-011 SHALL increment current_time_step after each completed TSTEP sweep, wrapping TIME_STEP-1 to 0.
REQ-012 SHALL, in a TREF sweep, assert time_ref_event, NEUR_CS and NEUR_WE for 1 cycle per neuron, with no reads. On completion it clears current_time_step to 0.
REQ-013 SHALL clear each pending flag when its sweep starts; a CTRL pulse in that same cycle re-sets the flag.
REQ-014 SHALL hold the neuron index counter at 0 outside sweeps; the index wraps to 0 at POST_NEUR_NUM-1 with the end-of-sweep transition.
REQ-015 SHALL keep CTRL_BUSY=1 in every state except IDLE.
REQ-016 SHALL ensure that at most one of neuron_event, time_step_event and time_ref_event is high in any cycle; all three are 0 in IDLE.

Reset
REQ-017 SHALL, while RST=1, force state IDLE and clear the pending flags, index, and current_time_step. All outputs read 0, including both ACK/REQ outputs and all SRAM selects and enables.
REQ-018 SHALL abort any sweep on RST; partially written SRAM contents are not restored.

Structure
REQ-019 SHALL take the FSM state encoding and the derived widths clog2(POST_NEUR_NUM) and clog2(TIME_STEP) from the shared snn_ff package.
REQ-020 SHALL be a single module with no sub-modules; the AER output handshake stays inline in the FSM.

Verification
REQ-021 One AER event, POST_NEUR_NUM=4, addr 0x005: SYN_ADDR steps 0x005_0..3 and neuron_event fires 4 times. AERIN_ACK rises 12 cycles after leaving IDLE and falls 1 cycle after REQ drops.
REQ-022 TSTEP with neuron 2 spiking: AEROUT_ADDR=2 and AEROUT_REQ held until ACK. The sweep resumes at neuron 3, and current_time_step goes 0->1.
REQ-023 8 TSTEP sweeps with TIME_STEP=8: current_time_step wraps 7->0.
REQ-024 CTRL_TREF and AERIN_REQ in the same cycle during an AER sweep: the AER sweep completes, TREF runs next, time_ref_event is asserted 4 cycles, and current_time_step=0.
REQ-025 RST asserted mid TS_SPK: next cycle is IDLE with AEROUT_REQ=0, NEUR_WE=0 and pending flags cleared.
REQ-026 Assertion on every cycle: the event strobes are one-hot-or-zero, and NEUR_WE implies NEUR_CS.
